fan_speed_writer: RTL and testbench

- Write side of the fan speed interface: accepts an 8-bit speed write for one of four fans, addressed by a one-hot fan selection, and holds it in a target register.
- Drives one PWM output per fan from an active duty register. Active duty is reloaded only at PWM period boundaries, so no output glitches mid-period.
- Target registers are exported as speed_fan0..3 and feed the existing read mux directly, so a readback returns the last value written.

---
 rtl/fan_speed_writer.sv | 132 +++++++++++++
 tb/tb_fan_speed_writer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fan_speed_writer.sv
// -----------------------------------------------------------------------------
// fan_speed_writer
//
// Purpose:
//   Write side of the fan speed interface. An 8-bit speed write is steered to
//   one of four target registers by a one-hot fan selection. The targets feed
//   the read mux directly, so a readback returns the last value written. Each
//   fan has a PWM output driven from an active duty register. Active duty is
//   reloaded from the target only at a PWM period boundary, so an output never
//   glitches mid-period.
//
// Optional feature (macro FAN_SOFT_START_EN):
//   When defined, each active duty steps by 1 toward its target at every
//   period boundary instead of jumping straight to it. When undefined, the
//   active duty loads the target directly at the boundary.
//
// Parameters:
//   PRESCALE      clk cycles per PWM counter tick (1..65535)
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset (dominates all inputs)
//   speed_in      [7:0] speed value to write
//   fan_selection [3:0] one-hot fan select, bit i = fan i
//   write         write strobe, sampled on rising clk
//   speed_fan0..3 [7:0] target speed per fan (to read mux)
//   pwm_out       [3:0] PWM drive, bit i drives fan i
//   write_err     one-cycle pulse after a rejected write
// -----------------------------------------------------------------------------
module fan_speed_writer #(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] speed_in,
    input  logic [3:0] fan_selection,
    input  logic       write,
    output logic [7:0] speed_fan0,
    output logic [7:0] speed_fan1,
    output logic [7:0] speed_fan2,
    output logic [7:0] speed_fan3,
    output logic [3:0] pwm_out,
    output logic       write_err
);

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);
    localparam logic [7:0]  COUNT_LAST    = 8'd254;

    // Write handshake: write is a plain strobe with no ready / back-pressure.
    // Every rising edge with write=1 is a write attempt; it is accepted when
    // fan_selection is exactly one-hot and rejected (write_err pulse) otherwise.

    logic [15:0] prescaler;
    logic [7:0]  pwm_count;
    logic [7:0]  target      [4];
    logic [7:0]  active_duty [4];

    logic tick;
    logic boundary;
    logic sel_valid;

    assign tick     = (prescaler == PRESCALE_LAST);
    // Last tick of a period: the counter wraps and active duties reload.
    assign boundary = tick && (pwm_count == COUNT_LAST);

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign sel_valid = (fan_selection != 4'd0) &&
                       ((fan_selection & (fan_selection - 4'd1)) == 4'd0);

    assign speed_fan0 = target[0];
    assign speed_fan1 = target[1];
    assign speed_fan2 = target[2];
    assign speed_fan3 = target[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= 16'd0;
            pwm_count <= 8'd0;
            pwm_out   <= 4'd0;
            write_err <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                target[i]      <= 8'd0;
                active_duty[i] <= 8'd0;
            end
        end else begin
            write_err <= write && !sel_valid;

            if (write && sel_valid) begin
                for (int i = 0; i < 4; i++) begin
                    if (fan_selection[i]) begin
                        target[i] <= speed_in;
                    end
                end
            end

            if (tick) begin
                prescaler <= 16'd0;
                // Period is 255 ticks; value 255 is never reached so that
                // duty 255 yields a constant-high output.
                if (pwm_count == COUNT_LAST) begin
                    pwm_count <= 8'd0;
                end else begin
                    pwm_count <= pwm_count + 8'd1;
                end
            end else begin
                prescaler <= prescaler + 16'd1;
            end

            // Registered compare using pre-edge counter and duty values.
            for (int i = 0; i < 4; i++) begin
                pwm_out[i] <= (pwm_count < active_duty[i]);
            end

            // The reload reads the pre-edge target, so a write landing on the
            // boundary edge only takes effect at the following boundary.
            if (boundary) begin
                for (int i = 0; i < 4; i++) begin
`ifdef FAN_SOFT_START_EN
                    if (active_duty[i] < target[i]) begin
                        active_duty[i] <= active_duty[i] + 8'd1;
                    end else if (active_duty[i] > target[i]) begin
                        active_duty[i] <= active_duty[i] - 8'd1;
                    end
`else
                    active_duty[i] <= target[i];
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_fan_speed_writer.sv
// -----------------------------------------------------------------------------
// tb_fan_speed_writer
//
// Self-checking bench for fan_speed_writer. Main instance uses PRESCALE=1
// (period = 255 clks); a second instance with the default PRESCALE=4 checks
// the prescaled period. Expected values are pushed to exp_q when stimulus is
// driven and popped when the corresponding DUT output is sampled.
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_fan_speed_writer;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] speed_in;
    logic [3:0] fan_selection;
    logic       write;

    logic [7:0] speed_fan0, speed_fan1, speed_fan2, speed_fan3;
    logic [3:0] pwm_out;
    logic       write_err;

    logic [7:0] s4_fan0, s4_fan1, s4_fan2, s4_fan3;
    logic [3:0] pwm4;
    logic       err4;

    always #5 clk = ~clk;

    fan_speed_writer #(.PRESCALE(1)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .speed_in      (speed_in),
        .fan_selection (fan_selection),
        .write         (write),
        .speed_fan0    (speed_fan0),
        .speed_fan1    (speed_fan1),
        .speed_fan2    (speed_fan2),
        .speed_fan3    (speed_fan3),
        .pwm_out       (pwm_out),
        .write_err     (write_err)
    );

    fan_speed_writer #(.PRESCALE(4)) u_dut4 (
        .clk           (clk),
        .reset         (reset),
        .speed_in      (speed_in),
        .fan_selection (fan_selection),
        .write         (write),
        .speed_fan0    (s4_fan0),
        .speed_fan1    (s4_fan1),
        .speed_fan2    (s4_fan2),
        .speed_fan3    (s4_fan3),
        .pwm_out       (pwm4),
        .write_err     (err4)
    );

    // Non-reset edges since reset release; boundary edges are multiples of 255
    // for PRESCALE=1 and multiples of 1020 for PRESCALE=4.
    int unsigned edge_cnt;
    always @(posedge clk) begin
        if (reset) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    // ---------------- model + scoreboard ----------------
    logic [7:0]  exp_target [4];
    logic [7:0]  exp_active [4];
    logic [15:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    function automatic logic [7:0] step_duty(input logic [7:0] a, input logic [7:0] t);
`ifdef FAN_SOFT_START_EN
        if (a < t)      return 8'(a + 8'd1);
        else if (a > t) return 8'(a - 8'd1);
        else            return a;
`else
        return t;
`endif
    endfunction

    task automatic push(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [15:0] obs);
        logic [15:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed %0d", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock; the model applies the boundary reload using pre-edge targets.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset && edge_cnt != 0 && (edge_cnt % 255) == 0) begin
            for (int i = 0; i < 4; i++) exp_active[i] = step_duty(exp_active[i], exp_target[i]);
        end
    endtask

    task automatic idle_inputs();
        write         = 1'b0;
        fan_selection = 4'($urandom_range(0, 15));
        speed_in      = 8'($urandom_range(0, 255));
    endtask

    task automatic apply_target(input logic [3:0] sel, input logic [7:0] val);
        if ($onehot(sel)) begin
            for (int i = 0; i < 4; i++) if (sel[i]) exp_target[i] = val;
        end
    endtask

    task automatic do_write(input logic [3:0] sel, input logic [7:0] val);
        write = 1'b1; fan_selection = sel; speed_in = val;
        tick();
        idle_inputs();
        apply_target(sel, val);
    endtask

    task automatic wait_boundary();
        do tick(); while ((edge_cnt % 255) != 0);
    endtask

    // Counts high clks of each pwm bit over one full period (must start just
    // after a boundary). Optionally issues a write at loop index wr_at.
    task automatic measure_period(input int wr_at, input logic [3:0] sel,
                                  input logic [7:0] val, input string tag);
        int hi [4];
        for (int i = 0; i < 4; i++) begin
            hi[i] = 0;
            push(16'(exp_active[i]));
        end
        for (int c = 0; c < 255; c++) begin
            if (c == wr_at) begin
                write = 1'b1; fan_selection = sel; speed_in = val;
            end
            tick();
            for (int b = 0; b < 4; b++) hi[b] += int'(pwm_out[b]);
            if (c == wr_at) begin
                idle_inputs();
                apply_target(sel, val);
            end
        end
        for (int b = 0; b < 4; b++) check($sformatf("%s_pwm%0d", tag, b), 16'(hi[b]));
    endtask

    task automatic check_targets(input string tag);
        push(16'(exp_target[0])); check({tag, "_fan0"}, 16'(speed_fan0));
        push(16'(exp_target[1])); check({tag, "_fan1"}, 16'(speed_fan1));
        push(16'(exp_target[2])); check({tag, "_fan2"}, 16'(speed_fan2));
        push(16'(exp_target[3])); check({tag, "_fan3"}, 16'(speed_fan3));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            exp_target[i] = 8'd0;
            exp_active[i] = 8'd0;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        int bad;
        int hi4_0, hi4_1;

        model_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) tick();

        // Reset state
        check_targets("reset");
        push(16'd0); check("reset_pwm", 16'(pwm_out));
        push(16'd0); check("reset_err", 16'(write_err));
        push(16'd0); check("reset_pwm_p4", 16'(pwm4));

        // Idle: nothing may move while write stays low
        reset = 1'b0;
        bad = 0;
        repeat (600) begin
            tick();
            if (pwm_out != 4'd0 || write_err || speed_fan0 != 8'd0 || speed_fan1 != 8'd0 ||
                speed_fan2 != 8'd0 || speed_fan3 != 8'd0) bad++;
        end
        push(16'd0); check("idle_activity", 16'(bad));

        // Valid write to fan1, 1-cycle latency, then 128/255 duty
        do_write(4'b0010, 8'h80);
        check_targets("w80");
        push(16'd0); check("w80_err", 16'(write_err));
        wait_boundary();
        measure_period(-1, 4'b0000, 8'h00, "w80");

        // Full and zero duty over 3 periods
        do_write(4'b1000, 8'hFF);
        do_write(4'b0001, 8'h00);
        wait_boundary();
        repeat (3) measure_period(-1, 4'b0000, 8'h00, "full_empty");

        // Invalid writes back to back: two-hot then zero
        write = 1'b1; fan_selection = 4'b0110; speed_in = 8'hAA;
        tick();
        push(16'd1); check("inv_err_0110", 16'(write_err));
        fan_selection = 4'b0000; speed_in = 8'h55;
        tick();
        push(16'd1); check("inv_err_0000", 16'(write_err));
        idle_inputs();
        tick();
        push(16'd0); check("inv_err_clear", 16'(write_err));
        check_targets("inv");

        // Mid-period write keeps the current period; boundary-edge write defers
        do_write(4'b0100, 8'h10);
        wait_boundary();
        measure_period(100, 4'b0100, 8'h40, "mid");
        measure_period(254, 4'b0100, 8'h20, "edge");
        measure_period(-1, 4'b0000, 8'h00, "defer");
        measure_period(-1, 4'b0000, 8'h00, "after");

        // Ramp (soft start steps 1,2,3,3; direct load gives 3 each period)
        do_write(4'b0001, 8'h03);
        wait_boundary();
        repeat (4) measure_period(-1, 4'b0000, 8'h00, "ramp");

        // Reset mid-period while fan0 output is high
        do_write(4'b0001, 8'hC8);
        wait_boundary();
        tick();
        push(16'd1); check("pre_reset_pwm0", 16'(pwm_out[0]));
        reset = 1'b1;
        tick();
        model_reset();
        push(16'd0); check("mid_reset_pwm0", 16'(pwm_out[0]));
        push(16'd0); check("mid_reset_fan0", 16'(speed_fan0));
        push(16'd0); check("mid_reset_pwm", 16'(pwm_out));
        tick();
        reset = 1'b0;

        // Prescaled instance: period 1020 clks, high count = 4 * duty
        do_write(4'b0010, 8'h05);
        push(16'h05); check("p4_fan1", 16'(s4_fan1));
        push(16'd0);  check("p4_others", 16'(s4_fan0 | s4_fan2 | s4_fan3) | 16'(err4));
        while (edge_cnt < 1020) tick();
        hi4_0 = 0; hi4_1 = 0;
        repeat (1020) begin
            tick();
            hi4_0 += int'(pwm4[0]);
            hi4_1 += int'(pwm4[1]);
        end
        push(16'(4 * int'(step_duty(8'd0, 8'h05)))); check("p4_pwm1", 16'(hi4_1));
        push(16'd0); check("p4_pwm0", 16'(hi4_0));

        // Main instance after reset restarts from counter 0
        measure_period(-1, 4'b0000, 8'h00, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
